rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: req0 = EXU/ALU result, req1 = LSU load result.
- Round-robin arbitration with valid/ready handshake.
- One registered output stage drives the register file wen/waddr/wdata.
- A pending-write scoreboard gives the decode stage per-operand hazard flags.
- Sits between EXU/LSU writeback and the register file; the decoder queries hazards through it.

---
 rtl/rf_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 46 ++++
 rtl/rf_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
// Types and constants shared by the register-file writeback arbiter.
//   RF_ADDR_WIDTH / RF_DATA_WIDTH : default register index / data widths
//   wb_req_t                      : one writeback request (valid, addr, data)
//   REQ_EXU / REQ_LSU             : requester slot indices (ALU, load unit)
// ----------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    localparam int REQ_EXU = 0;
    localparam int REQ_LSU = 1;

    // The record is sized by the package constants; retarget the widths here.
    typedef struct packed {
        logic                     valid;
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. A lone requester is granted; on a tie the
// grant goes to the requester that was not granted last. The tie-break
// pointer only moves on an actual grant and favours req[0] out of reset.
//   clk, rst  : clock, asynchronous active-high reset
//   req[1:0]  : request lines
//   gnt[1:0]  : one-hot (or zero) grant, combinational from req
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // prio_q = index of the requester that wins the next tie.
    logic prio_q;
    logic prio_d;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt    = req;
        prio_d = prio_q;
        if (req == 2'b11) begin
            gnt = prio_q ? 2'b10 : 2'b01;
        end
        if (gnt[0]) begin
            prio_d = 1'b1;
        end else if (gnt[1]) begin
            prio_d = 1'b0;
        end
    end

    // NOTE: flops use non-blocking assignment so every register samples
    // its pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the single register-file write port between the EXU (req0) and the
// LSU (req1) with round-robin arbitration, registers the winner into a
// one-stage output that drives the register file, and keeps a pending-write
// scoreboard that decode queries for operand hazards.
//   req0_* / req1_*        : valid/ready writeback requests (addr, data)
//   rf_wen/waddr/wdata     : registered register-file write port
//   set_en/set_addr        : decode marks a destination register pending
//   flush                  : clears every pending bit
//   raddr1/2 -> hazard1/2  : pending lookup for the decode operands
//   idle                   : nothing pending and the output stage is empty
// ----------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic                  hazard1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  hazard2,
    output logic                  idle
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    wb_req_t       req [2];
    wb_req_t       sel;
    logic [1:0]    req_valid;
    logic [1:0]    gnt;

    logic                  rf_wen_q,   rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [NUM_REGS-1:0]   pending_q,  pending_d;

    assign req[REQ_EXU] = '{valid: req0_valid, addr: req0_addr, data: req0_data};
    assign req[REQ_LSU] = '{valid: req1_valid, addr: req1_addr, data: req1_data};
    assign req_valid    = {req[REQ_LSU].valid, req[REQ_EXU].valid};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .gnt (gnt)
    );

    assign req0_ready = gnt[REQ_EXU];
    assign req1_ready = gnt[REQ_LSU];

    // With no LSU grant this picks the EXU slot, whose valid is then high
    // exactly when the EXU was granted, so sel.valid means "some grant".
    assign sel = gnt[REQ_LSU] ? req[REQ_LSU] : req[REQ_EXU];

    // Output stage: the register file accepts every cycle, so a grant always
    // loads. A write to x0 is consumed but never enables the register file.
    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (sel.valid) begin
            rf_wen_d   = (sel.addr != '0);
            rf_waddr_d = sel.addr;
            rf_wdata_d = sel.data;
        end
    end

    // Scoreboard: clear on the commit edge, then set (a newer producer of
    // the same register wins), then flush overrides both.
    always_comb begin
        pending_d = pending_q;
        if (rf_wen_q) begin
            pending_d[rf_waddr_q] = 1'b0;
        end
        if (set_en && (set_addr != '0)) begin
            pending_d[set_addr] = 1'b1;
        end
        if (flush) begin
            pending_d = '0;
        end
        pending_d[0] = 1'b0;
    end

    // NOTE: the pending vector is reset, unlike a data array, because it is
    // control state that decode reads as hazards straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // pending_q[0] is held at 0, so x0 operands never report a hazard.
    assign hazard1 = pending_q[raddr1];
    assign hazard2 = pending_q[raddr2];
    assign idle    = ~(|pending_q) & ~rf_wen_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Drives directed scenarios and random traffic into rf_wb_arbiter. A
// reference model (last-granted requester, pending flags per register, the
// write in flight) predicts ready/hazard/idle every cycle and queues each
// expected register-file write with the cycle it must appear in; a separate
// monitor pops the queue whenever the DUT asserts rf_wen.
// ----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          set_en;
    logic [AW-1:0] set_addr;
    logic          flush;
    logic [AW-1:0] raddr1, raddr2;
    logic          hazard1, hazard2, idle;

    rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .set_en     (set_en),
        .set_addr   (set_addr),
        .flush      (flush),
        .raddr1     (raddr1),
        .hazard1    (hazard1),
        .raddr2     (raddr2),
        .hazard2    (hazard2),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state.
    bit            pend [NREG];
    bit            infl_v;
    logic [AW-1:0] infl_a;
    int            last_gnt;
    bit            hold0, hold1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        infl_v   = 1'b0;
        infl_a   = '0;
        last_gnt = 1;   // behaves as if req1 won last, so req0 wins the first tie
        hold0    = 1'b0;
        hold1    = 1'b0;
        exp_q.delete();
    endtask

    task automatic clear_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        set_en     = 1'b0;
        flush      = 1'b0;
    endtask

    // Called just after a rising edge: checks this cycle at the falling edge,
    // advances the model to the next edge, and returns just after it.
    task automatic tick();
        bit            g0, g1, any_pend;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        g0 = req0_valid && (!req1_valid || last_gnt == 1);
        g1 = req1_valid && (!req0_valid || last_gnt == 0);
        any_pend = 1'b0;
        foreach (pend[i]) if (pend[i]) any_pend = 1'b1;
        check("req0_ready", 32'(req0_ready), 32'(g0));
        check("req1_ready", 32'(req1_ready), 32'(g1));
        check("hazard1", 32'(hazard1), 32'(raddr1 != 0 && pend[raddr1]));
        check("hazard2", 32'(hazard2), 32'(raddr2 != 0 && pend[raddr2]));
        check("idle", 32'(idle), 32'(!any_pend && !infl_v));

        if (infl_v) pend[infl_a] = 1'b0;
        if (set_en && set_addr != 0) pend[set_addr] = 1'b1;
        if (flush) foreach (pend[i]) pend[i] = 1'b0;
        infl_v = 1'b0;
        if (g0 || g1) begin
            a        = g0 ? req0_addr : req1_addr;
            d        = g0 ? req0_data : req1_data;
            last_gnt = g0 ? 0 : 1;
            if (a != 0) begin
                infl_v = 1'b1;
                infl_a = a;
                exp_q.push_back('{addr: a, data: d, cyc: cyc + 1});
            end
        end
        hold0 = req0_valid && !g0;
        hold1 = req1_valid && !g1;
        @(posedge clk);
        #1;
    endtask

    // Random traffic; a requester that was not granted keeps its request.
    task automatic rand_inputs(input bit allow_new);
        if (!hold0) begin
            req0_valid = allow_new && ($urandom_range(0, 99) < 50);
            req0_addr  = AW'($urandom_range(0, 7));
            req0_data  = $urandom;
        end
        if (!hold1) begin
            req1_valid = allow_new && ($urandom_range(0, 99) < 50);
            req1_addr  = AW'($urandom_range(0, 7));
            req1_data  = $urandom;
        end
        set_en   = ($urandom_range(0, 99) < 30);
        set_addr = AW'($urandom_range(0, 7));
        flush    = allow_new && ($urandom_range(0, 99) < 3);
        raddr1   = AW'($urandom_range(0, 7));
        raddr2   = AW'($urandom_range(0, 7));
    endtask

    // Asserts reset mid-cycle and checks the outputs clear without a clock.
    task automatic apply_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_rf_wen", 32'(rf_wen), 32'd0);
        check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check("rst_rf_wdata", rf_wdata, 32'd0);
        check("rst_hazard1", 32'(hazard1), 32'd0);
        check("rst_hazard2", 32'(hazard2), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: every write the DUT presents must be the oldest expected one,
    // in exactly the cycle the model scheduled it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) continue;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL missed_write: got no rf_wen, expected waddr=%0d in cycle %0d", exp_q[0].addr, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (rf_wen) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_write: got rf_wen=1 waddr=%0d in cycle %0d, expected rf_wen=0", rf_waddr, cyc);
                end else begin
                    check("rf_waddr", 32'(rf_waddr), 32'(exp_q[0].addr));
                    check("rf_wdata", rf_wdata, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no end of test, expected finish within 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        clear_inputs();
        req0_addr = '0;
        req0_data = '0;
        req1_addr = '0;
        req1_data = '0;
        set_addr  = '0;
        raddr1    = '0;
        raddr2    = '0;
        model_reset();

        #2;
        check("por_rf_wen", 32'(rf_wen), 32'd0);
        check("por_idle", 32'(idle), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Contention straight out of reset: grants 0,1,0,1, writes 1,2,1,2.
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            req0_valid = 1'b1; req0_addr = AW'(1); req0_data = 32'hA000_0001;
            req1_valid = 1'b1; req1_addr = AW'(2); req1_data = 32'hB000_0002;
            tick();
        end
        clear_inputs(); tick();

        // Single requester with a pending destination.
        clear_inputs(); set_en = 1'b1; set_addr = AW'(5); tick();
        clear_inputs(); req0_valid = 1'b1; req0_addr = AW'(5); req0_data = 32'hDEAD_BEEF;
        raddr1 = AW'(5); tick();
        clear_inputs(); tick();
        clear_inputs(); tick();

        // Write to x0: accepted, no register-file write.
        clear_inputs(); req1_valid = 1'b1; req1_addr = '0; req1_data = 32'h0000_1234; tick();
        clear_inputs(); tick();

        // Same-cycle set and clear of register 7: set wins.
        clear_inputs(); set_en = 1'b1; set_addr = AW'(7); tick();
        clear_inputs(); req0_valid = 1'b1; req0_addr = AW'(7); req0_data = 32'h7777_0007; tick();
        clear_inputs(); set_en = 1'b1; set_addr = AW'(7); raddr2 = AW'(7); tick();
        clear_inputs(); tick();
        clear_inputs(); req1_valid = 1'b1; req1_addr = AW'(7); req1_data = 32'h7777_0008; tick();
        clear_inputs(); tick();
        clear_inputs(); tick();

        // Flush beats a same-cycle set; the in-flight write still goes out.
        clear_inputs(); set_en = 1'b1; set_addr = AW'(4); tick();
        clear_inputs(); set_en = 1'b1; set_addr = AW'(9);
        req0_valid = 1'b1; req0_addr = AW'(4); req0_data = 32'h4444_0004; tick();
        clear_inputs(); flush = 1'b1; set_en = 1'b1; set_addr = AW'(6);
        raddr1 = AW'(4); raddr2 = AW'(9); tick();
        clear_inputs(); raddr1 = AW'(6); tick();
        clear_inputs(); tick();

        // Reset mid-cycle with register 3 pending and the stage loaded.
        clear_inputs(); set_en = 1'b1; set_addr = AW'(3); tick();
        clear_inputs(); req0_valid = 1'b1; req0_addr = AW'(4); req0_data = 32'h5555_AAAA; tick();
        clear_inputs(); raddr1 = AW'(3);
        apply_reset();
        clear_inputs(); tick();

        // Random traffic, then drain with no new requests.
        for (int i = 0; i < 1500; i++) begin
            rand_inputs(1'b1);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            rand_inputs(1'b0);
            tick();
        end
        clear_inputs();
        tick();
        tick();
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
